// File: rtl/uart_tx_config_if.sv
// Handshake and line bundle between the response formatter (master) and the
// configurable UART transmitter (slave).
interface uart_tx_config_if #(
  parameter int DATA_BITS = 8
);
  logic                 has_data;
  logic [DATA_BITS-1:0] data_to_send;
  logic                 ready;
  logic                 sending_bit;
  logic                 is_transmitting;
  logic                 transmission_done;

  modport master (
    output has_data,
    output data_to_send,
    input  ready,
    input  sending_bit,
    input  is_transmitting,
    input  transmission_done
  );

  modport slave (
    input  has_data,
    input  data_to_send,
    output ready,
    output sending_bit,
    output is_transmitting,
    output transmission_done
  );
endinterface

// File: rtl/uart_tx_config.sv
// Configurable UART transmitter: 5..9 data bits (LSB first), none/odd/even
// parity, 1 or 2 stop bits. Frame is latched on the accept edge, every bit is
// held CLOCKS_PER_BIT cycles, and completion raises a one-cycle done pulse.
module uart_tx_config #(
  parameter int CLOCKS_PER_BIT = 87,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic            clock,
  input  logic            reset,
  uart_tx_config_if.slave bus
);

  localparam int BAUD_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Reject illegal frame formats at elaboration instead of truncating them.
  generate
    if (CLOCKS_PER_BIT < 2 || CLOCKS_PER_BIT > 65535) begin : g_bad_cpb
      $error("uart_tx_config: CLOCKS_PER_BIT must be 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_config: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_tx_config: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_config: STOP_BITS must be 1 or 2");
    end
  endgenerate

  logic [2:0]           r_state;
  logic [BAUD_W-1:0]    r_baud;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_line;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;

  logic w_bit_end;
  logic w_parity_calc;

  // A bit period ends on the last baud count of any non-idle state.
  assign w_bit_end = (r_state != S_IDLE) && (r_baud == BAUD_LAST);

  // Even parity is the XOR of the payload; odd parity is its inverse.
  assign w_parity_calc = (PARITY_MODE == 1) ? ~(^bus.data_to_send) : (^bus.data_to_send);

  assign bus.ready             = r_ready;
  assign bus.sending_bit       = r_line;
  assign bus.is_transmitting   = r_busy;
  assign bus.transmission_done = r_done;

  // Baud counter: idles at zero, counts through each bit and wraps at its end.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_baud <= '0;
    end else if (r_state == S_IDLE || w_bit_end) begin
      r_baud <= '0;
    end else begin
      r_baud <= r_baud + 1'b1;
    end
  end

  // Frame sequencer: accept, then start/data/parity/stop with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_line    <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.has_data) begin
            r_shift   <= bus.data_to_send;
            r_parity  <= w_parity_calc;
            r_bit_cnt <= '0;
            r_state   <= S_START;
            r_line    <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_line    <= r_shift[0];
            r_bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == DATA_LAST) begin
              r_bit_cnt <= '0;
              if (PARITY_MODE != 0) begin
                r_state <= S_PARITY;
                r_line  <= r_parity;
              end else begin
                r_state <= S_STOP;
                r_line  <= 1'b1;
              end
            end else begin
              // Shift the next payload bit into position 0 and put it on the line.
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shift   <= r_shift >> 1;
              r_line    <= r_shift[1];
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state   <= S_STOP;
            r_line    <= 1'b1;
            r_bit_cnt <= '0;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_bit_cnt == STOP_LAST) begin
              r_state   <= S_IDLE;
              r_bit_cnt <= '0;
              r_ready   <= 1'b1;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_bit_cnt <= '0;
          r_line    <= 1'b1;
          r_ready   <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_config.sv
// Scoreboard bench for uart_tx_config across four frame formats. Expected
// frames are queued when a request is driven; per-instance monitors capture
// the line cycle by cycle and compare against the model when a frame ends.
`timescale 1ns/1ps
module tb_uart_tx_config;

  localparam int NCFG = 4;

  // cfg0: 8N1 CPB4, cfg1: 7E2 CPB4, cfg2: 9O1 CPB4, cfg3: 8N1 CPB2
  function automatic int cfg_cpb(int c);
    return (c == 3) ? 2 : 4;
  endfunction
  function automatic int cfg_db(int c);
    return (c == 1) ? 7 : ((c == 2) ? 9 : 8);
  endfunction
  function automatic int cfg_par(int c);
    return (c == 1) ? 2 : ((c == 2) ? 1 : 0);
  endfunction
  function automatic int cfg_stop(int c);
    return (c == 1) ? 2 : 1;
  endfunction

  typedef struct {
    int          cfg;
    logic [15:0] bits;
    int          nbits;
    int          abort_len;
    logic [8:0]  data;
  } exp_t;

  exp_t exp_q[$];

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [NCFG-1:0] has_data_a;
  logic [8:0]      data_a [NCFG];
  logic [NCFG-1:0] ready_a;
  logic [NCFG-1:0] line_a;
  logic [NCFG-1:0] tx_a;
  logic [NCFG-1:0] done_a;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Bit-level model of one frame: start, data LSB first, optional parity, stops.
  function automatic exp_t model(int c, logic [8:0] d, int abort_len);
    exp_t e;
    int   p;
    logic x;
    e.cfg       = c;
    e.data      = d;
    e.abort_len = abort_len;
    e.bits      = '0;
    p           = 0;
    x           = 1'b0;
    e.bits[p]   = 1'b0;
    p++;
    for (int i = 0; i < cfg_db(c); i++) begin
      e.bits[p] = d[i];
      x         = x ^ d[i];
      p++;
    end
    if (cfg_par(c) != 0) begin
      e.bits[p] = (cfg_par(c) == 2) ? x : ~x;
      p++;
    end
    for (int i = 0; i < cfg_stop(c); i++) begin
      e.bits[p] = 1'b1;
      p++;
    end
    e.nbits = p;
    return e;
  endfunction

  task automatic finish_frame(int c, int n, logic [63:0] wave, logic done_seen);
    exp_t        e;
    int          len;
    logic [63:0] w;
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 64'(c + 1), 64'd0);
      return;
    end
    e   = exp_q.pop_front();
    len = (e.abort_len != 0) ? e.abort_len : e.nbits * cfg_cpb(e.cfg);
    w   = '0;
    for (int k = 0; k < len && k < 64; k++) w[k] = e.bits[k / cfg_cpb(e.cfg)];
    $display("frame cfg=%0d data=0x%0h busy_cycles=%0d done=%0b", c, e.data, n, done_seen);
    check("frame_cfg", 64'(c), 64'(e.cfg));
    check("frame_len", 64'(n), 64'(len));
    check("line_wave", wave, w);
    check("done_pulse", 64'(done_seen), (e.abort_len != 0) ? 64'd0 : 64'd1);
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int DB = cfg_db(gi);

    uart_tx_config_if #(.DATA_BITS(DB)) bus ();

    assign bus.has_data     = has_data_a[gi];
    assign bus.data_to_send = data_a[gi][DB-1:0];
    assign ready_a[gi]      = bus.ready;
    assign line_a[gi]       = bus.sending_bit;
    assign tx_a[gi]         = bus.is_transmitting;
    assign done_a[gi]       = bus.transmission_done;

    uart_tx_config #(
      .CLOCKS_PER_BIT (cfg_cpb(gi)),
      .DATA_BITS      (DB),
      .PARITY_MODE    (cfg_par(gi)),
      .STOP_BITS      (cfg_stop(gi))
    ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
    );

    // Monitor: record the line on every busy cycle; frame ends when busy drops.
    initial begin : mon
      int          n;
      logic [63:0] wave;
      bit          in_frame;
      bit          clr_chk;
      logic        prev_tx;
      n        = 0;
      wave     = '0;
      in_frame = 1'b0;
      clr_chk  = 1'b0;
      prev_tx  = 1'b0;
      forever begin
        @(negedge clock);
        if (clr_chk) begin
          check("done_width", 64'(done_a[gi]), 64'd0);
          clr_chk = 1'b0;
        end
        if (in_frame) begin
          if (tx_a[gi] === 1'b1) begin
            if (n < 64) wave[n] = line_a[gi];
            n++;
          end else begin
            in_frame = 1'b0;
            finish_frame(gi, n, wave, done_a[gi]);
            clr_chk = (done_a[gi] === 1'b1);
          end
        end
        if (!in_frame && tx_a[gi] === 1'b1 && prev_tx !== 1'b1) begin
          in_frame = 1'b1;
          n        = 1;
          wave     = '0;
          wave[0]  = line_a[gi];
        end
        prev_tx = tx_a[gi];
      end
    end
  end

  task automatic send(int c, logic [8:0] d, int abort_len);
    int w;
    w = 0;
    @(negedge clock);
    while (ready_a[c] !== 1'b1 && w < 500) begin
      @(negedge clock);
      w++;
    end
    if (w >= 500) check("ready_timeout", 64'(ready_a[c]), 64'd1);
    exp_q.push_back(model(c, d, abort_len));
    data_a[c]     = d;
    has_data_a[c] = 1'b1;
    @(posedge clock);
    #1;
    has_data_a[c] = 1'b0;
    data_a[c]     = ~d;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(negedge clock);
      w++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    has_data_a = '0;
    for (int c = 0; c < NCFG; c++) data_a[c] = '0;

    // Asynchronous reset takes effect before any clock edge.
    #1 reset = 1'b1;
    #1;
    for (int c = 0; c < NCFG; c++) begin
      check("rst_line",  64'(line_a[c]),  64'd1);
      check("rst_ready", 64'(ready_a[c]), 64'd1);
      check("rst_busy",  64'(tx_a[c]),    64'd0);
      check("rst_done",  64'(done_a[c]),  64'd0);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    send(0, 9'h0A5, 0); drain();
    send(1, 9'h053, 0); drain();
    send(2, 9'h1FF, 0); drain();
    send(2, 9'h000, 0); drain();
    send(3, 9'h0FF, 0); drain();

    // Continuous request with data changing each cycle: accepts every 41 cycles.
    for (int j = 0; j < 123; j++) begin
      @(negedge clock);
      data_a[0]     = 9'($urandom_range(0, 255));
      has_data_a[0] = 1'b1;
      if (j % 41 == 0) exp_q.push_back(model(0, data_a[0], 0));
    end
    @(negedge clock);
    has_data_a[0] = 1'b0;
    drain();

    // Reset halfway through data bit 3 aborts the frame immediately.
    send(0, 9'h05A, 18);
    repeat (18) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("abort_line",  64'(line_a[0]),  64'd1);
    check("abort_busy",  64'(tx_a[0]),    64'd0);
    check("abort_ready", 64'(ready_a[0]), 64'd1);
    has_data_a[0] = 1'b1;
    data_a[0]     = 9'h055;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset         = 1'b0;
    has_data_a[0] = 1'b0;
    @(negedge clock);
    check("rst_wins_busy", 64'(tx_a[0]),   64'd0);
    check("rst_wins_line", 64'(line_a[0]), 64'd1);
    drain();

    send(0, 9'h03C, 0); drain();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
